// File: rtl/battle_turn_sequencer.sv
// Turn sequencer for a two-party battle: player select/strike, enemy think/strike, win/abort handling.
// Optional macro SELECT_TIMEOUT_EN bounds the player selection window to TIMEOUT_CYCLES cycles.
module battle_turn_sequencer #(
   parameter int unsigned TURN_CYCLES    = 2,
   parameter int unsigned TIMEOUT_CYCLES = 1000,
   parameter logic [7:0]  LFSR_SEED      = 8'hA5
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       collision_detected,
   input  logic       btn_valid,
   input  logic [1:0] btn_choice,
   input  logic [4:0] player_remained_sword,
   input  logic [4:0] player_remained_baseballbat,
   input  logic [4:0] enemy_remained_sword,
   input  logic [4:0] enemy_remained_baseballbat,
   input  logic       player_win,
   input  logic       enemy_win,
   output logic [1:0] player_choice,
   output logic [1:0] enemy_choice,
   output logic       player_turn,
   output logic       attacker_turn,
   output logic       battle_active,
   output logic [7:0] round_count,
   output logic       select_timeout
);

   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] P_SELECT = 3'd1;
   localparam logic [2:0] P_STRIKE = 3'd2;
   localparam logic [2:0] E_THINK  = 3'd3;
   localparam logic [2:0] E_STRIKE = 3'd4;
   localparam logic [2:0] DONE     = 3'd5;

   localparam int          TW        = 16;
   localparam logic [TW-1:0] TURN_LAST = TW'(TURN_CYCLES - 1);
`ifdef SELECT_TIMEOUT_EN
   localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
`endif

   logic [2:0]    r_state;
   logic [2:0]    w_next_state;
   logic [TW-1:0] r_timer;
   logic [7:0]    r_lfsr;
   logic          w_lfsr_fb;
   logic          w_in_battle;
   logic          w_sel_expired;
   logic [1:0]    w_btn_sub;
   logic [1:0]    w_enemy_sub;
   logic [1:0]    r_player_choice;
   logic [1:0]    r_enemy_choice;
   logic          r_player_turn;
   logic          r_attacker_turn;
   logic          r_battle_active;
   logic [7:0]    r_round_count;
`ifdef SELECT_TIMEOUT_EN
   logic          r_select_timeout;
`endif

   assign w_lfsr_fb   = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
   assign w_in_battle = (r_state == P_SELECT) || (r_state == P_STRIKE) ||
                        (r_state == E_THINK)  || (r_state == E_STRIKE);

`ifdef SELECT_TIMEOUT_EN
   assign w_sel_expired = (r_timer == TMO_LAST);
`else
   assign w_sel_expired = 1'b0;
`endif

   // A depleted weapon falls back to fist.
   assign w_btn_sub   = ((btn_choice == 2'd1 && player_remained_sword == 5'd0) ||
                         (btn_choice == 2'd2 && player_remained_baseballbat == 5'd0)) ? 2'd0 : btn_choice;
   assign w_enemy_sub = ((r_lfsr[1:0] == 2'd1 && enemy_remained_sword == 5'd0) ||
                         (r_lfsr[1:0] == 2'd2 && enemy_remained_baseballbat == 5'd0)) ? 2'd0 : r_lfsr[1:0];

   always_comb begin
      // NOTE: default assignment first so every path assigns w_next_state and no latch is inferred.
      w_next_state = r_state;
      case (r_state)
         IDLE:     if (collision_detected)           w_next_state = P_SELECT;
         P_SELECT: if (btn_valid || w_sel_expired)   w_next_state = P_STRIKE;
         P_STRIKE: if (r_timer == TURN_LAST)         w_next_state = E_THINK;
         E_THINK:                                    w_next_state = E_STRIKE;
         E_STRIKE: if (r_timer == TURN_LAST)         w_next_state = P_SELECT;
         DONE:     if (!collision_detected)          w_next_state = IDLE;
         default:                                    w_next_state = IDLE;
      endcase
      // Win flags outrank a lost collision, which outranks normal sequencing.
      if (w_in_battle) begin
         if (player_win || enemy_win)  w_next_state = DONE;
         else if (!collision_detected) w_next_state = IDLE;
      end
   end

   // NOTE: async reset clears every flop here; sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state          <= IDLE;
         r_timer          <= '0;
         r_lfsr           <= LFSR_SEED;
         r_player_choice  <= 2'd0;
         r_enemy_choice   <= 2'd0;
         r_player_turn    <= 1'b0;
         r_attacker_turn  <= 1'b0;
         r_battle_active  <= 1'b0;
         r_round_count    <= 8'd0;
`ifdef SELECT_TIMEOUT_EN
         r_select_timeout <= 1'b0;
`endif
      end else begin
         r_lfsr          <= {r_lfsr[6:0], w_lfsr_fb};
         r_state         <= w_next_state;
         r_timer         <= (w_next_state != r_state) ? '0 : r_timer + TW'(1);
         r_player_turn   <= (w_next_state == P_STRIKE);
         r_attacker_turn <= (w_next_state == E_STRIKE);
         r_battle_active <= (w_next_state != IDLE);
`ifdef SELECT_TIMEOUT_EN
         r_select_timeout <= 1'b0;
`endif
         if (r_state == IDLE && w_next_state == P_SELECT)
            r_round_count <= 8'd0;
         if (r_state == E_STRIKE && w_next_state == P_SELECT && r_round_count != 8'hFF)
            r_round_count <= r_round_count + 8'd1;
         if (r_state == P_SELECT && w_next_state == P_STRIKE) begin
`ifdef SELECT_TIMEOUT_EN
            if (btn_valid) begin
               r_player_choice <= w_btn_sub;
            end else begin
               r_player_choice  <= 2'd0;
               r_select_timeout <= 1'b1;
            end
`else
            r_player_choice <= w_btn_sub;
`endif
         end
         if (r_state == E_THINK && w_next_state == E_STRIKE)
            r_enemy_choice <= w_enemy_sub;
      end
   end

   assign player_choice  = r_player_choice;
   assign enemy_choice   = r_enemy_choice;
   assign player_turn    = r_player_turn;
   assign attacker_turn  = r_attacker_turn;
   assign battle_active  = r_battle_active;
   assign round_count    = r_round_count;
`ifdef SELECT_TIMEOUT_EN
   assign select_timeout = r_select_timeout;
`else
   assign select_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_battle_turn_sequencer.sv
// Self-checking bench for battle_turn_sequencer: directed sequences, a substitution table,
// and randomized traffic compared every cycle against a phase-level reference model.
module tb_battle_turn_sequencer;

   localparam int         TURN = 2;
   localparam int         TMO  = 8;
   localparam logic [7:0] SEED = 8'hA5;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       collision_detected = 1'b0;
   logic       btn_valid = 1'b0;
   logic [1:0] btn_choice = 2'd0;
   logic [4:0] p_sw = 5'd5, p_bat = 5'd5, e_sw = 5'd5, e_bat = 5'd5;
   logic       player_win = 1'b0, enemy_win = 1'b0;
   logic [1:0] player_choice, enemy_choice;
   logic       player_turn, attacker_turn, battle_active, select_timeout;
   logic [7:0] round_count;

   battle_turn_sequencer #(
      .TURN_CYCLES(TURN), .TIMEOUT_CYCLES(TMO), .LFSR_SEED(SEED)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .collision_detected(collision_detected),
      .btn_valid(btn_valid), .btn_choice(btn_choice),
      .player_remained_sword(p_sw), .player_remained_baseballbat(p_bat),
      .enemy_remained_sword(e_sw), .enemy_remained_baseballbat(e_bat),
      .player_win(player_win), .enemy_win(enemy_win),
      .player_choice(player_choice), .enemy_choice(enemy_choice),
      .player_turn(player_turn), .attacker_turn(attacker_turn),
      .battle_active(battle_active), .round_count(round_count),
      .select_timeout(select_timeout)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: battle phase plus remaining-cycle counters.
   typedef enum {M_IDLE, M_SEL, M_PSTR, M_THINK, M_ESTR, M_DONE} phase_t;
   phase_t     m_phase;
   int         m_left, m_wait, m_round;
   logic [1:0] m_pc, m_ec;
   bit         m_to;
   logic [7:0] m_lfsr;

   typedef struct {
      logic [1:0] choice;
      logic [4:0] sw;
      logic [4:0] bat;
      logic [1:0] exp_choice;
   } sub_vec_t;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   function automatic logic [1:0] sub(input logic [1:0] c, input logic [4:0] sw, input logic [4:0] bat);
      if ((c == 2'd1 && sw == 5'd0) || (c == 2'd2 && bat == 5'd0)) return 2'd0;
      return c;
   endfunction

   task automatic model_reset();
      m_phase = M_IDLE; m_left = 0; m_wait = 0; m_round = 0;
      m_pc = 2'd0; m_ec = 2'd0; m_to = 1'b0; m_lfsr = SEED;
   endtask

   task automatic model_step();
      m_to = 1'b0;
      if (m_phase == M_IDLE) begin
         if (collision_detected) begin m_phase = M_SEL; m_round = 0; m_wait = 0; end
      end else if (m_phase == M_DONE) begin
         if (!collision_detected) m_phase = M_IDLE;
      end else if (player_win || enemy_win) begin
         m_phase = M_DONE;
      end else if (!collision_detected) begin
         m_phase = M_IDLE;
      end else begin
         case (m_phase)
            M_SEL: begin
               m_wait++;
               if (btn_valid) begin
                  m_pc = sub(btn_choice, p_sw, p_bat); m_phase = M_PSTR; m_left = TURN;
               end
`ifdef SELECT_TIMEOUT_EN
               else if (m_wait == TMO) begin
                  m_pc = 2'd0; m_to = 1'b1; m_phase = M_PSTR; m_left = TURN;
               end
`endif
            end
            M_PSTR: begin m_left--; if (m_left == 0) m_phase = M_THINK; end
            M_THINK: begin m_ec = sub(m_lfsr[1:0], e_sw, e_bat); m_phase = M_ESTR; m_left = TURN; end
            M_ESTR: begin
               m_left--;
               if (m_left == 0) begin
                  if (m_round < 255) m_round++;
                  m_phase = M_SEL; m_wait = 0;
               end
            end
            default: ;
         endcase
      end
      m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
   endtask

   task automatic compare_model();
      check("player_choice",  int'(player_choice),  int'(m_pc));
      check("enemy_choice",   int'(enemy_choice),   int'(m_ec));
      check("player_turn",    int'(player_turn),    int'(m_phase == M_PSTR));
      check("attacker_turn",  int'(attacker_turn),  int'(m_phase == M_ESTR));
      check("battle_active",  int'(battle_active),  int'(m_phase != M_IDLE));
      check("round_count",    int'(round_count),    m_round);
      check("select_timeout", int'(select_timeout), int'(m_to));
      check("strobe_overlap", int'(player_turn & attacker_turn), 0);
   endtask

   // Inputs are changed at the falling edge; outputs are compared at the next falling edge.
   task automatic cycle();
      @(posedge clk);
      if (rst_n) model_step();
      @(negedge clk);
      compare_model();
   endtask

   task automatic press(input logic [1:0] c);
      btn_choice = c; btn_valid = 1'b1;
      cycle();
      btn_valid = 1'b0;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      sub_vec_t vecs[9];
      vecs[0] = '{2'd0, 5'd0,  5'd0,  2'd0};
      vecs[1] = '{2'd1, 5'd5,  5'd5,  2'd1};
      vecs[2] = '{2'd1, 5'd0,  5'd5,  2'd0};
      vecs[3] = '{2'd2, 5'd5,  5'd5,  2'd2};
      vecs[4] = '{2'd2, 5'd5,  5'd0,  2'd0};
      vecs[5] = '{2'd3, 5'd0,  5'd0,  2'd3};
      vecs[6] = '{2'd1, 5'd0,  5'd0,  2'd0};
      vecs[7] = '{2'd2, 5'd1,  5'd31, 2'd2};
      vecs[8] = '{2'd1, 5'd1,  5'd0,  2'd1};

      // Reset values
      model_reset();
      @(negedge clk);
      compare_model();
      check("reset_battle_active", int'(battle_active), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Basic round with kick
      collision_detected = 1'b1;
      cycle();
      check("sel_active", int'(battle_active), 1);
      press(2'd3);
      check("kick_choice", int'(player_choice), 3);
      check("pstrike_1", int'(player_turn), 1);
      cycle();
      check("pstrike_2", int'(player_turn), 1);
      cycle();
      check("think_pturn", int'(player_turn), 0);
      check("think_aturn", int'(attacker_turn), 0);
      cycle();
      check("estrike_1", int'(attacker_turn), 1);
      cycle();
      check("estrike_2", int'(attacker_turn), 1);
      cycle();
      check("round_end_aturn", int'(attacker_turn), 0);
      check("round_one", int'(round_count), 1);

      // Depletion substitution table
      for (int i = 0; i < 9; i++) begin
         p_sw = vecs[i].sw; p_bat = vecs[i].bat;
         press(vecs[i].choice);
         check($sformatf("sub_vec%0d", i), int'(player_choice), int'(vecs[i].exp_choice));
         run(5);
      end
      check("rounds_after_table", int'(round_count), 10);
      p_sw = 5'd5; p_bat = 5'd5;

      // Collision lost during player strike
      press(2'd2);
      collision_detected = 1'b0;
      cycle();
      check("abort_pturn", int'(player_turn), 0);
      check("abort_active", int'(battle_active), 0);
      check("abort_keep_choice", int'(player_choice), 2);
      collision_detected = 1'b1;
      cycle();
      check("reentry_round_clear", int'(round_count), 0);

      // Enemy win during enemy strike
      press(2'd0);
      run(3);
      check("pre_win_aturn", int'(attacker_turn), 1);
      enemy_win = 1'b1;
      cycle();
      enemy_win = 1'b0;
      check("done_aturn", int'(attacker_turn), 0);
      check("done_pturn", int'(player_turn), 0);
      check("done_active", int'(battle_active), 1);
      run(3);
      check("done_hold", int'(battle_active), 1);
      collision_detected = 1'b0;
      cycle();
      check("done_exit", int'(battle_active), 0);

      // Async reset mid enemy strike
      collision_detected = 1'b1;
      cycle();
      press(2'd1);
      run(3);
      check("pre_rst_aturn", int'(attacker_turn), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_aturn", int'(attacker_turn), 0);
      check("async_rst_echoice", int'(enemy_choice), 0);
      check("async_rst_pchoice", int'(player_choice), 0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      cycle();
      press(2'd3);
      run(5);

`ifdef SELECT_TIMEOUT_EN
      // Timeout: no button for the whole window
      for (int i = 0; i < TMO - 1; i++) begin
         cycle();
         check("tmo_wait_pulse", int'(select_timeout), 0);
      end
      cycle();
      check("tmo_pulse", int'(select_timeout), 1);
      check("tmo_choice", int'(player_choice), 0);
      check("tmo_pturn", int'(player_turn), 1);
      cycle();
      check("tmo_pulse_end", int'(select_timeout), 0);
      run(4);
      // Button in the last window cycle wins over timeout
      run(TMO - 1);
      press(2'd2);
      check("tmo_last_btn_choice", int'(player_choice), 2);
      check("tmo_last_btn_pulse", int'(select_timeout), 0);
      run(5);
`else
      run(40);
      check("no_tmo_pulse", int'(select_timeout), 0);
      check("no_tmo_pturn", int'(player_turn), 0);
      check("no_tmo_active", int'(battle_active), 1);
      press(2'd0);
      run(5);
`endif

      // Randomized traffic against the model
      for (int i = 0; i < 4000; i++) begin
         collision_detected = ($urandom_range(0, 99) < 96);
         btn_valid  = ($urandom_range(0, 99) < 25);
         btn_choice = 2'($urandom_range(0, 3));
         player_win = ($urandom_range(0, 99) < 2);
         enemy_win  = ($urandom_range(0, 99) < 2);
         p_sw  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         p_bat = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         e_sw  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         e_bat = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         cycle();
      end

      // Round counter saturation
      player_win = 1'b0; enemy_win = 1'b0; btn_valid = 1'b0; collision_detected = 1'b0;
      do_reset();
      collision_detected = 1'b1;
      btn_valid = 1'b1;
      for (int i = 0; i < 1700; i++) begin
         btn_choice = 2'($urandom_range(0, 3));
         cycle();
      end
      btn_valid = 1'b0;
      check("round_saturate", int'(round_count), 255);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/battle_turn_sequencer.md
BATTLE_TURN_SEQUENCER -- requirements
Module: battle_turn_sequencer

Interface
REQ-001 Parameter TURN_CYCLES, default 2: cycles each turn strobe stays high.
REQ-002 Parameter TIMEOUT_CYCLES, default 1000: player selection window in cycles; used only under SELECT_TIMEOUT_EN.
REQ-003 Parameter LFSR_SEED, default 8'hA5: enemy LFSR reset value; must be non-zero.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  system clock, all state on rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 collision_detected  in  1  high while player and enemy are in contact (battle context).
REQ-008 btn_valid  in  1  one-cycle pulse, player selection present.
REQ-009 btn_choice  in  2  player move: 00 fist, 01 sword, 10 baseballbat, 11 kick.
REQ-010 player_remained_sword, player_remained_baseballbat, enemy_remained_sword, enemy_remained_baseballbat  in  5 each  weapon stock from game engine.
REQ-011 player_win, enemy_win  in  1 each  game-engine result flags.
REQ-012 player_choice, enemy_choice  out  2 each  registered moves presented to game engine.
REQ-013 player_turn, attacker_turn  out  1 each  turn strobes to game engine.
REQ-014 battle_active  out  1  high in any state other than IDLE.
REQ-015 round_count  out  8  completed player+enemy rounds in current battle.
REQ-016 select_timeout  out  1  one-cycle pulse when player selection times out.

Function
REQ-017 FSM states: IDLE, P_SELECT, P_STRIKE, E_THINK, E_STRIKE, DONE.
REQ-018 IDLE -> P_SELECT on collision_detected high; round_count cleared to 0 on this transition.
REQ-019 P_SELECT: on btn_valid, latch btn_choice into player_choice, go P_STRIKE next cycle; btn_valid outside P_SELECT SHALL be ignored.
REQ-020 Depleted substitution: selecting 01 with player_remained_sword==0 or 10 with player_remained_baseballbat==0 SHALL latch 00.
REQ-021 P_STRIKE: player_turn=1, attacker_turn=0 for exactly TURN_CYCLES cycles, then E_THINK.
REQ-022 E_THINK: one cycle; enemy_choice <= LFSR[1:0] with same depletion substitution against enemy stocks; LFSR advances every clock in any state (x^8+x^6+x^5+x^4+1, Fibonacci).
REQ-023 E_STRIKE: attacker_turn=1, player_turn=0 for exactly TURN_CYCLES cycles; on exit round_count increments (saturating at 255) and state returns to P_SELECT.
REQ-024 player_turn and attacker_turn SHALL never be high in the same cycle.
REQ-025 player_win or enemy_win high in any battle state SHALL force DONE next cycle, deasserting both strobes; win flags have priority over every other transition.
REQ-026 DONE holds choices and round_count; returns to IDLE only when collision_detected is low.
REQ-027 collision_detected low in P_SELECT..E_STRIKE SHALL abort to IDLE next cycle, strobes low, choices retained.
REQ-028 All outputs registered; latency btn_valid -> player_turn rising = 1 cycle.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, player_choice=00, enemy_choice=00, player_turn=0, attacker_turn=0, battle_active=0, round_count=0, select_timeout=0, LFSR=LFSR_SEED, timers=0.
REQ-030 Reset asserted mid-strobe SHALL drop the strobe asynchronously; release resumes at IDLE.

Configuration
REQ-031 Macro SELECT_TIMEOUT_EN defined: counter runs in P_SELECT; after TIMEOUT_CYCLES cycles without btn_valid, player_choice=00, select_timeout pulses one cycle, state goes to P_STRIKE; btn_valid in the final window cycle wins over timeout.
REQ-032 SELECT_TIMEOUT_EN undefined: no counter, select_timeout tied 0, P_SELECT waits indefinitely.

Verification
REQ-033 Reset, collision 1, btn_valid with choice 11 -> player_choice=11, player_turn high 2 cycles, then attacker_turn high 2 cycles, round_count=1.
REQ-034 btn_choice 01 with player_remained_sword=0 -> player_choice=00.
REQ-035 collision drops during P_STRIKE -> next cycle IDLE, player_turn=0, battle_active=0.
REQ-036 enemy_win asserted during E_STRIKE -> DONE next cycle, strobes 0; stays DONE until collision 0, then IDLE.
REQ-037 SELECT_TIMEOUT_EN, TIMEOUT_CYCLES=8, no btn_valid -> select_timeout pulse at cycle 8, player_choice=00, player_turn rises.
REQ-038 rst_n low during attacker_turn high -> attacker_turn 0 without clock edge, enemy_choice=00, LFSR=8'hA5.
